mcpu_fetch_unit: RTL and testbench

MCPU_FETCH_UNIT -- requirements
Module: mcpu_fetch_unit

---
 rtl/mcpu_fetch_unit.sv | 93 +++++++++
 tb/tb_mcpu_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_fetch_unit.sv
// Instruction fetch unit: PC register feeding a 2-entry {pc, word} prefetch buffer.
// Branch redirects flush the buffer; halt freezes the PC and lets the buffer drain.
module mcpu_fetch_unit #(
    parameter int unsigned           WORD_SIZE  = 8,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] instraddr,
    input  logic [WORD_SIZE-1:0]  instrrd,
    output logic [WORD_SIZE-1:0]  instr_out,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  branch_en,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    input  logic                  halt,
    output logic [1:0]            occupancy
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0]  head_word_q, head_word_d, tail_word_q, tail_word_d;
    logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
    logic [1:0]            count_q, count_d, count_after_pop;
    logic                  pop, push;

    always_comb begin
        pop  = (count_q != 2'd0) && instr_ready;
        push = !branch_en && !halt && ((count_q != 2'd2) || pop);

        pc_d            = pc_q;
        head_word_d     = head_word_q;
        head_pc_d       = head_pc_q;
        tail_word_d     = tail_word_q;
        tail_pc_d       = tail_pc_q;
        count_after_pop = count_q;

        // Empty slots are kept zeroed so the head reads 0 when the buffer is empty.
        if (pop) begin
            head_word_d     = tail_word_q;
            head_pc_d       = tail_pc_q;
            tail_word_d     = '0;
            tail_pc_d       = '0;
            count_after_pop = count_q - 2'd1;
        end
        count_d = count_after_pop;

        if (branch_en) begin
            head_word_d = '0;
            head_pc_d   = '0;
            tail_word_d = '0;
            tail_pc_d   = '0;
            count_d     = 2'd0;
            pc_d        = branch_addr;
        end else if (push) begin
            if (count_after_pop == 2'd0) begin
                head_word_d = instrrd;
                head_pc_d   = pc_q;
            end else begin
                tail_word_d = instrrd;
                tail_pc_d   = pc_q;
            end
            count_d = count_after_pop + 2'd1;
            pc_d    = pc_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            head_word_q <= '0;
            head_pc_q   <= '0;
            tail_word_q <= '0;
            tail_pc_q   <= '0;
            count_q     <= 2'd0;
        end else begin
            pc_q        <= pc_d;
            head_word_q <= head_word_d;
            head_pc_q   <= head_pc_d;
            tail_word_q <= tail_word_d;
            tail_pc_q   <= tail_pc_d;
            count_q     <= count_d;
        end
    end

    assign instraddr   = pc_q;
    assign instr_out   = head_word_q;
    assign instr_pc    = head_pc_q;
    assign instr_valid = (count_q != 2'd0);
    assign occupancy   = count_q;

endmodule

// File: tb/tb_mcpu_fetch_unit.sv
// Bench for mcpu_fetch_unit: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mcpu_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instraddr;
    logic [7:0] instrrd;
    logic [7:0] instr_out;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       branch_en;
    logic [7:0] branch_addr;
    logic       halt;
    logic [1:0] occupancy;

    int n_pass  = 0;
    int n_total = 0;

    mcpu_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .instraddr   (instraddr),
        .instrrd     (instrrd),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .branch_en   (branch_en),
        .branch_addr (branch_addr),
        .halt        (halt),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input logic [7:0] a);
        case (a[2:0])
            3'd0: mem = 8'h04;
            3'd1: mem = 8'h06;
            3'd2: mem = 8'h05;
            3'd3: mem = 8'h04;
            3'd4: mem = 8'h04;
            3'd5: mem = 8'h07;
            3'd6: mem = 8'h03;
            default: mem = 8'h09;
        endcase
    endfunction

    assign instrrd = mem(instraddr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of {pc, word} entries and a fetch pointer.
    logic [15:0] mq[$];
    logic [7:0]  mpc;
    bit          live = 0;

    always @(posedge clk) begin : model
        int sz;
        bit mpop;
        if (reset) begin
            mq.delete();
            mpc  = 8'h00;
            live = 1;
        end else if (live) begin
            sz   = mq.size();
            mpop = (sz > 0) && instr_ready;
            if (mpop) void'(mq.pop_front());
            if (branch_en) begin
                mq.delete();
                mpc = branch_addr;
            end else if (!halt && (sz < 2 || mpop)) begin
                mq.push_back({mpc, mem(mpc)});
                mpc = mpc + 8'd1;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [15:0] head;
        if (live) begin
            head = (mq.size() != 0) ? mq[0] : 16'h0000;
            check("m_valid", 32'(instr_valid), 32'(mq.size() != 0));
            check("m_out", 32'(instr_out), 32'(head[7:0]));
            check("m_pc", 32'(instr_pc), 32'(head[15:8]));
            check("m_occ", 32'(occupancy), 32'(mq.size()));
            check("m_addr", 32'(instraddr), 32'(mpc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_w [4];
    logic [7:0] exp_p [4];

    initial begin
        reset       = 1'b1;
        instr_ready = 1'b0;
        branch_en   = 1'b0;
        branch_addr = 8'h00;
        halt        = 1'b0;
        step();
        step();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_out", 32'(instr_out), 32'd0);
        check("rst_pc", 32'(instr_pc), 32'd0);
        check("rst_addr", 32'(instraddr), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);

        // Streaming with constant ready
        exp_w[0] = 8'h04; exp_w[1] = 8'h06; exp_w[2] = 8'h05; exp_w[3] = 8'h04;
        exp_p[0] = 8'h00; exp_p[1] = 8'h01; exp_p[2] = 8'h02; exp_p[3] = 8'h03;
        reset       = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stream_valid", 32'(instr_valid), 32'd1);
            check("stream_out", 32'(instr_out), 32'(exp_w[i]));
            check("stream_pc", 32'(instr_pc), 32'(exp_p[i]));
            check("stream_occ", 32'(occupancy), 32'd1);
        end

        // Backpressure fills the buffer
        reset = 1'b1;
        step();
        check("rst2_valid", 32'(instr_valid), 32'd0);
        reset       = 1'b0;
        instr_ready = 1'b0;
        step();
        step();
        step();
        check("bp_occ", 32'(occupancy), 32'd2);
        check("bp_addr", 32'(instraddr), 32'h02);
        check("bp_out", 32'(instr_out), 32'h04);
        check("bp_pc", 32'(instr_pc), 32'h00);
        instr_ready = 1'b1;
        step();
        check("bp_rel_out", 32'(instr_out), 32'h06);
        check("bp_rel_pc", 32'(instr_pc), 32'h01);
        check("bp_rel_occ", 32'(occupancy), 32'd2);

        // Branch with full buffer, then wrap
        instr_ready = 1'b0;
        step();
        branch_en   = 1'b1;
        branch_addr = 8'hFE;
        step();
        check("br_occ", 32'(occupancy), 32'd0);
        check("br_valid", 32'(instr_valid), 32'd0);
        check("br_out", 32'(instr_out), 32'd0);
        check("br_addr", 32'(instraddr), 32'hFE);
        branch_en   = 1'b0;
        instr_ready = 1'b1;
        step();
        check("br_w0", 32'({instr_out, instr_pc}), 32'h03FE);
        step();
        check("br_w1", 32'({instr_out, instr_pc}), 32'h09FF);
        step();
        check("br_w2", 32'({instr_out, instr_pc}), 32'h0400);

        // Halt drains the buffer and freezes the PC
        instr_ready = 1'b0;
        step();
        check("h_fill", 32'(occupancy), 32'd2);
        halt        = 1'b1;
        instr_ready = 1'b1;
        step();
        check("h_pop1", 32'(occupancy), 32'd1);
        check("h_pop1_pc", 32'(instr_pc), 32'h01);
        step();
        step();
        check("h_empty", 32'(instr_valid), 32'd0);
        check("h_addr", 32'(instraddr), 32'h02);
        halt = 1'b0;
        step();
        check("h_res0", 32'({instr_out, instr_pc}), 32'h0502);
        step();
        check("h_res1", 32'(instr_pc), 32'h03);

        // Branch, halt and pop together; then reset over a full buffer
        instr_ready = 1'b0;
        step();
        check("c_fill", 32'(occupancy), 32'd2);
        branch_en   = 1'b1;
        halt        = 1'b1;
        instr_ready = 1'b1;
        branch_addr = 8'h10;
        step();
        check("c_occ", 32'(occupancy), 32'd0);
        check("c_addr", 32'(instraddr), 32'h10);
        branch_en   = 1'b0;
        halt        = 1'b0;
        instr_ready = 1'b0;
        step();
        step();
        check("c_fill2", 32'(occupancy), 32'd2);
        check("c_head", 32'({instr_out, instr_pc}), 32'h0410);
        reset       = 1'b1;
        instr_ready = 1'b1;
        branch_en   = 1'b1;
        halt        = 1'b1;
        step();
        check("c_rst_valid", 32'(instr_valid), 32'd0);
        check("c_rst_addr", 32'(instraddr), 32'h00);
        check("c_rst_occ", 32'(occupancy), 32'd0);
        reset     = 1'b0;
        branch_en = 1'b0;
        halt      = 1'b0;
        step();
        check("c_first", 32'({instr_out, instr_pc}), 32'h0400);
        step();
        step();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
